// File: rtl/mtm_alu_out_scheduler.sv
// Output scheduler between the ALU core and the serializer: buffers result and error
// frames, gives errors priority, and spaces launches by each frame's serial duration.
module mtm_alu_out_scheduler #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DATA_GAP = 56,
  parameter int unsigned ERR_GAP  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  input  logic [31:0] res_C,
  input  logic [7:0]  res_ctl,
  output logic        res_ready,
  input  logic        err_valid,
  input  logic [7:0]  err_ctl,
  output logic        err_ready,
  output logic [31:0] C,
  output logic [7:0]  CTL_out,
  output logic        busy,
  output logic        drop
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned GapW = $clog2(DATA_GAP + 1);

  localparam logic [PtrW:0]   FullCnt  = DEPTH[PtrW:0];
  localparam logic [PtrW:0]   CntOne   = {{PtrW{1'b0}}, 1'b1};
  localparam logic [PtrW-1:0] PtrOne   = {{(PtrW - 1){1'b0}}, 1'b1};
  localparam logic [GapW-1:0] GapOne   = {{(GapW - 1){1'b0}}, 1'b1};
  localparam logic [GapW-1:0] DataLoad = GapW'(DATA_GAP - 2);
  localparam logic [GapW-1:0] ErrLoad  = GapW'(ERR_GAP - 2);
  localparam logic [7:0]      CtlIdle  = 8'hFF;

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e          state_q;
  logic [39:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            err_pending_q;
  logic [7:0]      err_code_q;
  logic [GapW-1:0] gap_q;
  logic            is_err_q;

  logic res_hs, res_push, err_hs, err_ok, fifo_empty;
  logic launch_err, launch_res, drop_d;

  assign fifo_empty = (count_q == '0);
  assign res_ready  = (count_q != FullCnt);
  assign err_ready  = !err_pending_q;

  assign res_hs   = res_valid && res_ready;
  assign res_push = res_hs && !res_ctl[7];
  assign err_hs   = err_valid && err_ready;
  assign err_ok   = (err_ctl == 8'hC9) || (err_ctl == 8'h93) || (err_ctl == 8'hA5);
  // Both malformed sources in one cycle still give a single pulse.
  assign drop_d   = (res_hs && res_ctl[7]) || (err_hs && !err_ok);

  assign launch_err = (state_q == StIdle) && err_pending_q;
  assign launch_res = (state_q == StIdle) && !err_pending_q && !fifo_empty;

  assign busy = (state_q != StIdle) || err_pending_q || !fifo_empty;

  always_ff @(posedge clk) begin
    if (res_push) begin
      mem_q[wr_ptr_q] <= {res_ctl, res_C};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      err_pending_q <= 1'b0;
      err_code_q    <= 8'h00;
    end else begin
      if (res_push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (launch_res) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      unique case ({res_push, launch_res})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
      if (launch_err) begin
        err_pending_q <= 1'b0;
      end else if (err_hs && err_ok) begin
        err_pending_q <= 1'b1;
        err_code_q    <= err_ctl;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      C        <= 32'h0;
      CTL_out  <= CtlIdle;
      gap_q    <= '0;
      is_err_q <= 1'b0;
      drop     <= 1'b0;
    end else begin
      drop <= drop_d;
      case (state_q)
        StIdle: begin
          if (launch_err) begin
            state_q  <= StLaunch;
            C        <= 32'h0;
            CTL_out  <= err_code_q;
            is_err_q <= 1'b1;
          end else if (launch_res) begin
            state_q  <= StLaunch;
            C        <= mem_q[rd_ptr_q][31:0];
            CTL_out  <= mem_q[rd_ptr_q][39:32];
            is_err_q <= 1'b0;
          end
        end
        StLaunch: begin
          state_q <= StWait;
          CTL_out <= CtlIdle;
          gap_q   <= is_err_q ? ErrLoad : DataLoad;
        end
        StWait: begin
          // Leaving on gap==1 leaves one IDLE cycle, making the spacing exactly the gap.
          if (gap_q <= GapOne) begin
            state_q <= StIdle;
          end
          gap_q <= gap_q - GapOne;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_out_scheduler.sv
// Scoreboard bench: stimulus queues expected frames, a negedge monitor checks each launch
// for content, launch edge and spacing from the previous launch.
module tb_mtm_alu_out_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        res_valid = 1'b0;
  logic [31:0] res_C = '0;
  logic [7:0]  res_ctl = '0;
  logic        res_ready;
  logic        err_valid = 1'b0;
  logic [7:0]  err_ctl = '0;
  logic        err_ready;
  logic [31:0] C;
  logic [7:0]  CTL_out;
  logic        busy;
  logic        drop;

  mtm_alu_out_scheduler #(
    .DEPTH   (4),
    .DATA_GAP(56),
    .ERR_GAP (12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .res_valid(res_valid),
    .res_C    (res_C),
    .res_ctl  (res_ctl),
    .res_ready(res_ready),
    .err_valid(err_valid),
    .err_ctl  (err_ctl),
    .err_ready(err_ready),
    .C        (C),
    .CTL_out  (CTL_out),
    .busy     (busy),
    .drop     (drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // gap: expected edges since the previous launch (0 = unchecked);
  // edge_n: expected absolute launch edge (0 = unchecked).
  typedef struct {
    logic [31:0] c;
    logic [7:0]  ctl;
    int          gap;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   last_launch = 0;
  bit   chk_idle = 1'b0;
  int   acc_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // A launch is visible at the negedge following the launch edge (cyc = launch edge).
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      chk_idle = 1'b0;
    end else if (chk_idle) begin
      check("ctl_one_cycle", {24'h0, CTL_out}, 32'hFF);
      chk_idle = 1'b0;
    end else if (CTL_out !== 8'hFF) begin
      if (sb.size() == 0) begin
        check("unexpected_launch", {24'h0, CTL_out}, 32'hFF);
      end else begin
        e = sb.pop_front();
        check("launch_ctl", {24'h0, CTL_out}, {24'h0, e.ctl});
        check("launch_c", C, e.c);
        if (e.gap != 0) check("launch_spacing", cyc - last_launch, e.gap);
        if (e.edge_n != 0) check("launch_edge", cyc, e.edge_n);
      end
      last_launch = cyc;
      chk_idle = 1'b1;
    end
  end

  task automatic wait_edge(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_timeout", {31'h0, busy}, 32'h0);
  endtask

  // Waits for the needed ready(s), then offers the request for exactly one edge.
  task automatic push(input bit do_res, input logic [31:0] c, input logic [7:0] ctl,
                      input bit do_err, input logic [7:0] ecode);
    int t = 0;
    while (((do_res && !res_ready) || (do_err && !err_ready)) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t == 500) check("accept_timeout", 32'h0, 32'h1);
    res_valid = do_res;
    res_C     = c;
    res_ctl   = ctl;
    err_valid = do_err;
    err_ctl   = ecode;
    @(posedge clk);
    #1;
    acc_edge  = cyc;
    res_valid = 1'b0;
    err_valid = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int   l0;
    exp_t b_exp;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_C", C, 32'h0);
    check("rst_ctl", {24'h0, CTL_out}, 32'hFF);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_res_ready", {31'h0, res_ready}, 32'h1);
    check("rst_err_ready", {31'h0, err_ready}, 32'h1);
    check("rst_drop", {31'h0, drop}, 32'h0);

    // Single result: launch on edge n+1, busy drops once the gap's last WAIT cycle ends.
    push(1'b1, 32'hDEADBEEF, 8'h05, 1'b0, 8'h00);
    sb.push_back(exp_t'{32'hDEADBEEF, 8'h05, 0, acc_edge + 1});
    l0 = acc_edge + 1;
    wait_edge(l0 + 54);
    check("busy_before_idle", {31'h0, busy}, 32'h1);
    wait_edge(l0 + 55);
    check("busy_after_idle", {31'h0, busy}, 32'h0);

    // Back-to-back: lead frame in flight, then fill the FIFO and overflow by one.
    push(1'b1, 32'h1000_0000, 8'h01, 1'b0, 8'h00);
    l0 = acc_edge + 1;
    sb.push_back(exp_t'{32'h1000_0000, 8'h01, 0, l0});
    for (int i = 1; i <= 4; i++) begin
      push(1'b1, 32'h1000_0000 + i, 8'h10 + 8'(i), 1'b0, 8'h00);
      sb.push_back(exp_t'{32'h1000_0000 + i, 8'h10 + 8'(i), 56, 0});
    end
    check("full_res_ready", {31'h0, res_ready}, 32'h0);
    push(1'b1, 32'h1000_0005, 8'h15, 1'b0, 8'h00);
    sb.push_back(exp_t'{32'h1000_0005, 8'h15, 56, 0});
    check("fifth_accept_edge", acc_edge, l0 + 56 + 1);
    wait_idle();

    // Priority: error accepted during A's WAIT goes ahead of queued B.
    push(1'b1, 32'hAAAA_0001, 8'h0A, 1'b0, 8'h00);
    l0 = acc_edge + 1;
    sb.push_back(exp_t'{32'hAAAA_0001, 8'h0A, 0, l0});
    push(1'b1, 32'hBBBB_0002, 8'h0B, 1'b0, 8'h00);
    b_exp = exp_t'{32'hBBBB_0002, 8'h0B, 12, 0};
    wait_edge(l0 + 5);
    push(1'b0, 32'h0, 8'h00, 1'b1, 8'hC9);
    sb.push_back(exp_t'{32'h0, 8'hC9, 56, 0});
    sb.push_back(b_exp);
    wait_idle();

    // Malformed requests: one drop pulse each, nothing stored.
    push(1'b1, 32'h0000_0BAD, 8'h85, 1'b0, 8'h00);
    check("drop_res", {31'h0, drop}, 32'h1);
    @(posedge clk);
    #1;
    check("drop_res_end", {31'h0, drop}, 32'h0);
    check("bad_res_ready", {31'h0, res_ready}, 32'h1);
    check("bad_res_busy", {31'h0, busy}, 32'h0);
    push(1'b0, 32'h0, 8'h00, 1'b1, 8'h11);
    check("drop_err", {31'h0, drop}, 32'h1);
    check("bad_err_ready", {31'h0, err_ready}, 32'h1);
    @(posedge clk);
    #1;
    check("drop_err_end", {31'h0, drop}, 32'h0);
    check("bad_err_busy", {31'h0, busy}, 32'h0);
    push(1'b1, 32'h0000_0BAD, 8'hC0, 1'b1, 8'h00);
    check("drop_both", {31'h0, drop}, 32'h1);
    @(posedge clk);
    #1;
    check("drop_both_single", {31'h0, drop}, 32'h0);
    repeat (80) @(posedge clk);
    #1;
    check("bad_none_busy", {31'h0, busy}, 32'h0);

    // Simultaneous requests while idle: error first, result 12 edges later.
    push(1'b1, 32'hCAFEF00D, 8'h22, 1'b1, 8'hA5);
    sb.push_back(exp_t'{32'h0, 8'hA5, 0, acc_edge + 1});
    sb.push_back(exp_t'{32'hCAFEF00D, 8'h22, 12, 0});
    wait_idle();

    // Reset mid-WAIT with three results queued.
    push(1'b1, 32'h5555AAAA, 8'h33, 1'b0, 8'h00);
    l0 = acc_edge + 1;
    sb.push_back(exp_t'{32'h5555AAAA, 8'h33, 0, l0});
    for (int i = 0; i < 3; i++) push(1'b1, 32'h7700_0000 + i, 8'h40, 1'b0, 8'h00);
    wait_edge(l0 + 10);
    #3 rst = 1'b1;
    #1;
    check("midrst_C", C, 32'h0);
    check("midrst_ctl", {24'h0, CTL_out}, 32'hFF);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_res_ready", {31'h0, res_ready}, 32'h1);
    check("midrst_err_ready", {31'h0, err_ready}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check("post_rst_busy", {31'h0, busy}, 32'h0);
    check("sb_drained", sb.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
